bcd_to_binary: RTL and testbench

- Sequential BCD-to-binary converter using the reverse double-dabble (shift-right, subtract-3) algorithm.
- It is the inverse of the team's binary-to-BCD engine.
- It converts packed BCD digit strings, as entered from switches/keypad or received as decimal text, into binary for datapath use.
- START/DONE handshake. Single conversion in flight.

---
 rtl/bcd_to_binary.sv | 183 ++++++++++++++++++
 tb/tb_bcd_to_binary.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// bcd_to_binary
//   Sequential packed-BCD to binary converter (reverse double-dabble:
//   shift right, then subtract 3 from every digit that is >= 8).
//   START/DONE handshake, one conversion in flight.
//
//   Ports:
//     CLK       system clock, rising edge
//     RESETN    synchronous, active-low reset
//     BCD       packed BCD input, digit 0 in [3:0], sampled on accepted START
//     START     conversion request, accepted in IDLE
//     BINARY    registered result
//     ERROR     registered, input held a digit > 9
//     OVERFLOW  registered, result does not fit in OUTPUT_WIDTH
//     DONE      combinational, idle and no request pending
//
//   Build option: define BCD2BIN_PARALLEL_ADJUST_EN to correct all digits in
//   a single ADJUST cycle instead of walking them one at a time. Results are
//   identical in both builds; only the latency changes.
module bcd_to_binary #(
    parameter int DECIMAL_DIGITS = 8,
    parameter int OUTPUT_WIDTH   = 27
) (
    input  logic                          CLK,
    input  logic                          RESETN,
    input  logic [4*DECIMAL_DIGITS-1:0]   BCD,
    input  logic                          START,
    output logic [OUTPUT_WIDTH-1:0]       BINARY,
    output logic                          ERROR,
    output logic                          OVERFLOW,
    output logic                          DONE
);

    localparam int NB  = 4 * DECIMAL_DIGITS;
    localparam int LCW = $clog2(NB);

`ifdef BCD2BIN_PARALLEL_ADJUST_EN
    typedef enum logic [2:0] {
        S_IDLE, S_VALIDATE, S_SHIFT, S_CHECK_SHIFT, S_ADJUST
    } state_t;
`else
    localparam int DIW = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
    typedef enum logic [2:0] {
        S_IDLE, S_VALIDATE, S_SHIFT, S_CHECK_SHIFT, S_ADJUST, S_CHECK_DIGIT
    } state_t;
`endif

    state_t                  state, state_nxt;
    logic [NB-1:0]           bcd, bcd_nxt;
    logic [NB-1:0]           shreg, shreg_nxt;
    logic [LCW-1:0]          loop_count, loop_count_nxt;
    logic [OUTPUT_WIDTH-1:0] binary_nxt;
    logic                    error_nxt, overflow_nxt;
`ifndef BCD2BIN_PARALLEL_ADJUST_EN
    logic [DIW-1:0]          digit_index, digit_index_nxt;
`endif

    function automatic logic [3:0] adjust_digit(input logic [3:0] d);
        return (d >= 4'd8) ? (d - 4'd3) : d;
    endfunction

    function automatic logic has_invalid_digit(input logic [NB-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DECIMAL_DIGITS; i++)
            if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

`ifdef BCD2BIN_PARALLEL_ADJUST_EN
    function automatic logic [NB-1:0] adjust_all(input logic [NB-1:0] v);
        logic [NB-1:0] r;
        for (int i = 0; i < DECIMAL_DIGITS; i++)
            r[i*4 +: 4] = adjust_digit(v[i*4 +: 4]);
        return r;
    endfunction
`endif

    always_comb begin
        state_nxt      = state;
        bcd_nxt        = bcd;
        shreg_nxt      = shreg;
        loop_count_nxt = loop_count;
        binary_nxt     = BINARY;
        error_nxt      = ERROR;
        overflow_nxt   = OVERFLOW;
`ifndef BCD2BIN_PARALLEL_ADJUST_EN
        digit_index_nxt = digit_index;
`endif
        case (state)
            S_IDLE: begin
                if (START) begin
                    bcd_nxt        = BCD;
                    shreg_nxt      = '0;
                    loop_count_nxt = '0;
                    error_nxt      = 1'b0;
                    overflow_nxt   = 1'b0;
`ifndef BCD2BIN_PARALLEL_ADJUST_EN
                    digit_index_nxt = '0;
`endif
                    state_nxt      = S_VALIDATE;
                end
            end
            S_VALIDATE: begin
                if (has_invalid_digit(bcd)) begin
                    error_nxt  = 1'b1;
                    binary_nxt = '0;
                    state_nxt  = S_IDLE;
                end else begin
                    state_nxt  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // {bcd, shreg} behaves as one 2*NB-bit register shifted right.
                {bcd_nxt, shreg_nxt} = {1'b0, bcd, shreg[NB-1:1]};
                state_nxt = S_CHECK_SHIFT;
            end
            S_CHECK_SHIFT: begin
                if (loop_count == LCW'(NB - 1)) begin
                    binary_nxt = shreg[OUTPUT_WIDTH-1:0];
                    // Shifting by OUTPUT_WIDTH yields zero when the result
                    // uses the full register, so no special case is needed.
                    overflow_nxt = |(shreg >> OUTPUT_WIDTH);
                    state_nxt    = S_IDLE;
                end else begin
                    loop_count_nxt = loop_count + LCW'(1);
`ifndef BCD2BIN_PARALLEL_ADJUST_EN
                    digit_index_nxt = '0;
`endif
                    state_nxt = S_ADJUST;
                end
            end
`ifdef BCD2BIN_PARALLEL_ADJUST_EN
            S_ADJUST: begin
                bcd_nxt   = adjust_all(bcd);
                state_nxt = S_SHIFT;
            end
`else
            S_ADJUST: begin
                bcd_nxt[{digit_index, 2'b00} +: 4] =
                    adjust_digit(bcd[{digit_index, 2'b00} +: 4]);
                state_nxt = S_CHECK_DIGIT;
            end
            S_CHECK_DIGIT: begin
                if (digit_index == DIW'(DECIMAL_DIGITS - 1)) begin
                    state_nxt = S_SHIFT;
                end else begin
                    digit_index_nxt = digit_index + DIW'(1);
                    state_nxt       = S_ADJUST;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control and visible results are reset; a reset mid-run simply drops
    // the working registers, so no partial result can reach BINARY.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state    <= S_IDLE;
            BINARY   <= '0;
            ERROR    <= 1'b0;
            OVERFLOW <= 1'b0;
        end else begin
            state    <= state_nxt;
            BINARY   <= binary_nxt;
            ERROR    <= error_nxt;
            OVERFLOW <= overflow_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        bcd        <= bcd_nxt;
        shreg      <= shreg_nxt;
        loop_count <= loop_count_nxt;
`ifndef BCD2BIN_PARALLEL_ADJUST_EN
        digit_index <= digit_index_nxt;
`endif
    end

    assign DONE = (state == S_IDLE) && !START;

endmodule

// File: tb/tb_bcd_to_binary.sv
module tb_bcd_to_binary;

    localparam int D    = 8;
    localparam int WA   = 27;
    localparam int WB   = 20;
`ifdef BCD2BIN_PARALLEL_ADJUST_EN
    localparam int LAT_OK = 2 + 8*D + (4*D - 1);
`else
    localparam int LAT_OK = 2 + 8*D + 2*D*(4*D - 1);
`endif
    localparam int NRAND = 60;

    logic          CLK = 1'b0;
    logic          RESETN = 1'b0;
    logic [4*D-1:0] bcd_in = '0;
    logic          start = 1'b0;
    logic [WA-1:0] bin_a;
    logic          err_a, ovf_a, done_a;
    logic [WB-1:0] bin_b;
    logic          err_b, ovf_b, done_b;

    int tests  = 0;
    int failed = 0;

    always #5 CLK = ~CLK;

    bcd_to_binary #(.DECIMAL_DIGITS(D), .OUTPUT_WIDTH(WA)) dut_a (
        .CLK(CLK), .RESETN(RESETN), .BCD(bcd_in), .START(start),
        .BINARY(bin_a), .ERROR(err_a), .OVERFLOW(ovf_a), .DONE(done_a));

    bcd_to_binary #(.DECIMAL_DIGITS(D), .OUTPUT_WIDTH(WB)) dut_b (
        .CLK(CLK), .RESETN(RESETN), .BCD(bcd_in), .START(start),
        .BINARY(bin_b), .ERROR(err_b), .OVERFLOW(ovf_b), .DONE(done_b));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: decimal value of the digit string by plain arithmetic.
    function automatic longint bcd_value(input logic [31:0] v);
        longint r = 0;
        for (int i = 7; i >= 0; i--) r = r * 10 + longint'((v >> (4*i)) & 32'hF);
        return r;
    endfunction

    function automatic bit bcd_bad(input logic [31:0] v);
        for (int i = 0; i < 8; i++)
            if (((v >> (4*i)) & 32'hF) > 9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_result(input logic [31:0] v, input int lat);
        bit     bad;
        longint val;
        longint exp_a, exp_b;
        bad   = bcd_bad(v);
        val   = bad ? 0 : bcd_value(v);
        exp_a = val & ((longint'(1) << WA) - 1);
        exp_b = val & ((longint'(1) << WB) - 1);
        check("latency", 64'(lat), bad ? 64'd2 : 64'(LAT_OK));
        check("bin27",   64'(bin_a), 64'(exp_a));
        check("err27",   64'(err_a), 64'(bad));
        check("ovf27",   64'(ovf_a), 64'((val >> WA) != 0));
        check("bin20",   64'(bin_b), 64'(exp_b));
        check("err20",   64'(err_b), 64'(bad));
        check("ovf20",   64'(ovf_b), 64'((val >> WB) != 0));
        check("done20",  64'(done_b), 64'd1);
    endtask

    // Pulse START for one cycle; lat counts edges from the sampling edge
    // to the edge after which DONE is high again.
    task automatic convert(input logic [31:0] v, input int repulse_at, output int lat);
        @(negedge CLK);
        bcd_in = v;
        start  = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        lat = 1;
        while (!done_a && lat < 2000) begin
            if (lat == repulse_at) begin
                @(negedge CLK);
                bcd_in = 32'h0000_0777;
                start  = 1'b1;
                @(posedge CLK);
                #1 start = 1'b0;
            end else begin
                @(posedge CLK);
                #1;
            end
            lat++;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] v;

        repeat (3) @(posedge CLK);
        #1 RESETN = 1'b1;
        @(negedge CLK);
        check("rst_bin", 64'(bin_a), 64'd0);
        check("rst_err", 64'(err_a), 64'd0);
        check("rst_ovf", 64'(ovf_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd1);

        convert(32'h1234_5678, -1, lat);
        check_result(32'h1234_5678, lat);
        check("bin_12345678", 64'(bin_a), 64'h0BC614E);
        convert(32'h9999_9999, -1, lat);
        check_result(32'h9999_9999, lat);
        check("bin_all9", 64'(bin_a), 64'h5F5E0FF);
        convert(32'h0000_0000, -1, lat);
        check_result(32'h0000_0000, lat);
        convert(32'h123A_5678, -1, lat);
        check_result(32'h123A_5678, lat);
        convert(32'h0000_0042, -1, lat);
        check_result(32'h0000_0042, lat);
        check("bin_42", 64'(bin_a), 64'd42);
        convert(32'h0104_8576, -1, lat);
        check_result(32'h0104_8576, lat);
        check("ovf_1048576", 64'(ovf_b), 64'd1);
        convert(32'h0104_8575, -1, lat);
        check_result(32'h0104_8575, lat);
        check("bin_fffff", 64'(bin_b), 64'hFFFFF);

        // START while busy must be ignored.
        convert(32'h0000_0555, 10, lat);
        check_result(32'h0000_0555, lat);

        // Reset mid-conversion: outputs clear, nothing completes afterwards.
        @(negedge CLK);
        bcd_in = 32'h0000_0555;
        start  = 1'b1;
        @(negedge CLK);
        start  = 1'b0;
        repeat (20) @(negedge CLK);
        RESETN = 1'b0;
        @(posedge CLK);
        #1;
        check("midrst_bin", 64'(bin_a), 64'd0);
        check("midrst_done", 64'(done_a), 64'd1);
        RESETN = 1'b1;
        repeat (LAT_OK + 10) @(posedge CLK);
        #1;
        check("midrst_stale_bin", 64'(bin_a), 64'd0);
        check("midrst_stale_done", 64'(done_a), 64'd1);

        for (int n = 0; n < NRAND; n++) begin
            v = '0;
            for (int i = 0; i < 8; i++)
                v[i*4 +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0)
                v[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
            convert(v, -1, lat);
            check_result(v, lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
